frame_streamer: RTL and testbench

FRAME_STREAMER -- requirements
Module: frame_streamer

---
 rtl/frame_streamer_if.sv | 18 +
 rtl/frame_streamer.sv | 162 ++++++++++++++++
 tb/tb_frame_streamer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/frame_streamer_if.sv
// ============================================================================
// frame_streamer_if : pixel stream with line/frame markers and valid/ready
// Rev 1.0
// ============================================================================
`default_nettype none

interface frame_streamer_if;
    logic [23:0] data;
    logic        eol;
    logic        eof;
    logic        valid;
    logic        ready;

    modport master (output data, eol, eof, valid, input ready);
    modport slave  (input data, eol, eof, valid, output ready);
endinterface

`default_nettype wire

// File: rtl/frame_streamer.sv
// ============================================================================
// frame_streamer : captures one SRAM frame after an adapter wrap and streams
//                  it through a small FIFO. Macro STREAM_GRAY_EN stores luma.
// Rev 1.0
// ============================================================================
`default_nettype none

module frame_streamer #(
    parameter int IMG_DIM = 1024,
    parameter int FIFO_AW = 4
) (
    input  wire               clk,
    input  wire               rst,
    input  wire               start,
    input  wire        [23:0] pix_in,
    input  wire               done_in,
    frame_streamer_if.master  m,
    output logic              busy,
    output logic              overflow,
    output logic              frame_done
);

    localparam logic [9:0]         c_last  = 10'(IMG_DIM - 1);
    localparam logic [FIFO_AW:0]   c_depth = (FIFO_AW + 1)'(2 ** FIFO_AW);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SYNC   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DRAIN  = 2'd3
    } state_t;

    state_t              r_state;
    logic [9:0]          r_col;
    logic [9:0]          r_row;
    logic [25:0]         r_mem [0:(2**FIFO_AW)-1];
    logic [FIFO_AW-1:0]  r_wr_ptr;
    logic [FIFO_AW-1:0]  r_rd_ptr;
    logic [FIFO_AW:0]    r_count;

    logic        w_empty;
    logic        w_full;
    logic        w_pop;
    logic        w_push_req;
    logic        w_push;
    logic        w_drop;
    logic        w_eol;
    logic        w_eof;
    logic [23:0] w_pix;
    logic [25:0] w_head;

`ifdef STREAM_GRAY_EN
    logic [15:0] w_luma;
    assign w_luma = 16'd77  * {8'd0, pix_in[23:16]}
                  + 16'd150 * {8'd0, pix_in[15:8]}
                  + 16'd29  * {8'd0, pix_in[7:0]};
    assign w_pix  = {3{w_luma[15:8]}};
`else
    assign w_pix  = pix_in;
`endif

    assign w_eol      = (r_col == c_last);
    assign w_eof      = w_eol && (r_row == c_last);
    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == c_depth);
    assign w_pop      = !w_empty && m.ready;
    assign w_push_req = (r_state == ST_STREAM);
    // A full FIFO still takes the pixel when the head leaves in the same cycle.
    assign w_push     = w_push_req && (!w_full || w_pop);
    assign w_drop     = w_push_req && !w_push;

    // Head entry is shown only while valid so the bus reads zero when empty.
    assign w_head  = w_empty ? 26'd0 : r_mem[r_rd_ptr];
    assign m.valid = !w_empty;
    assign m.eof   = w_head[25];
    assign m.eol   = w_head[24];
    assign m.data  = w_head[23:0];

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= {w_eof, w_eol, w_pix};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= ST_IDLE;
            r_col      <= '0;
            r_row      <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            if (w_drop) begin
                overflow <= 1'b1;
            end
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state  <= ST_SYNC;
                        busy     <= 1'b1;
                        overflow <= 1'b0;
                        r_col    <= '0;
                        r_row    <= '0;
                    end
                end
                ST_SYNC: begin
                    if (done_in) begin
                        r_state <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    // Counters advance on every capture, dropped or not.
                    if (w_eol) begin
                        r_col <= '0;
                        r_row <= w_eof ? 10'd0 : r_row + 10'd1;
                    end else begin
                        r_col <= r_col + 10'd1;
                    end
                    if (w_eof) begin
                        r_state <= ST_DRAIN;
                    end
                end
                ST_DRAIN: begin
                    if (w_empty) begin
                        r_state    <= ST_IDLE;
                        busy       <= 1'b0;
                        frame_done <= 1'b1;
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    busy    <= 1'b0;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_frame_streamer.sv
// ============================================================================
// tb_frame_streamer : directed frames against a queue-based stream model
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_frame_streamer;

    localparam int DIM   = 4;
    localparam int N     = DIM * DIM;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        done_in = 1'b0;
    logic [23:0] pix_in = 24'd0;
    logic        busy;
    logic        overflow;
    logic        frame_done;

    frame_streamer_if sif ();

    frame_streamer #(.IMG_DIM(DIM), .FIFO_AW(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .pix_in     (pix_in),
        .done_in    (done_in),
        .m          (sif),
        .busy       (busy),
        .overflow   (overflow),
        .frame_done (frame_done)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct packed {
        logic        eof;
        logic        eol;
        logic [23:0] pix;
    } beat_t;

    beat_t mq[$];
    int    ph = 0;      // 0 idle, 1 waiting for wrap, 2 capturing, 3 draining
    int    mk = 0;
    bit    m_ovf = 0;
    bit    m_busy = 0;
    bit    m_fd = 0;

    function automatic logic [23:0] stored(input logic [23:0] p);
`ifdef STREAM_GRAY_EN
        int y;
        y = (77 * int'(p[23:16]) + 150 * int'(p[15:8]) + 29 * int'(p[7:0])) / 256;
        return {3{y[7:0]}};
`else
        return p;
`endif
    endfunction

    always @(posedge clk or negedge rst) begin : model
        int    sz;
        bit    pop;
        bit    take;
        beat_t b;
        if (!rst) begin
            mq.delete();
            ph = 0; mk = 0; m_ovf = 0; m_busy = 0; m_fd = 0;
        end else begin
            sz   = mq.size();
            pop  = (sz != 0) && sif.ready;
            take = 0;
            b    = '0;
            m_fd = 0;
            if (ph == 2) begin
                b.pix = stored(pix_in);
                b.eol = (mk % DIM) == DIM - 1;
                b.eof = (mk == N - 1);
                take  = (sz < DEPTH) || pop;
                if (!take) m_ovf = 1;
            end
            if (pop) void'(mq.pop_front());
            if (take) mq.push_back(b);
            case (ph)
                0: if (start) begin ph = 1; m_ovf = 0; end
                1: if (done_in) begin ph = 2; mk = 0; end
                2: begin mk++; if (mk == N) ph = 3; end
                default: if (sz == 0) begin ph = 0; m_fd = 1; end
            endcase
            m_busy = (ph != 0);
        end
    end

    always @(negedge clk) begin : compare
        chk("valid", sif.valid, 32'(mq.size() != 0));
        if (mq.size() != 0) begin
            chk("data", sif.data, mq[0].pix);
            chk("eol", sif.eol, mq[0].eol);
            chk("eof", sif.eof, mq[0].eof);
        end
        chk("busy", busy, m_busy);
        chk("overflow", overflow, m_ovf);
        chk("frame_done", frame_done, m_fd);
    end

    // ---------------- beat log ----------------
    logic [23:0] log_d [0:255];
    logic        log_l [0:255];
    logic        log_f [0:255];
    int          log_n = 0;
    int          fd_cnt = 0;

    always @(negedge clk) begin : monitor
        if (sif.valid && sif.ready && log_n < 256) begin
            log_d[log_n] = sif.data;
            log_l[log_n] = sif.eol;
            log_f[log_n] = sif.eof;
            log_n++;
        end
        if (frame_done) fd_cnt++;
    end

    logic [23:0] pix_tab [0:N-1];
    int          lb;
    int          fb;

    // inj: 0 none, 1 start+done_in pulses mid-stream, 2 reset at capture 7
    task automatic run_frame(input int ready_from, input int inj);
        int t;
        lb = log_n;
        fb = fd_cnt;
        sif.ready = (ready_from == 0);
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
        repeat (2) @(posedge clk);
        #1 done_in = 1'b1;
        @(posedge clk); #1 done_in = 1'b0;
        for (int k = 0; k < N; k++) begin
            pix_in = pix_tab[k];
            if (k >= ready_from) sif.ready = 1'b1;
            if (inj == 1 && k == 5) start = 1'b1;
            if (inj == 1 && k == 9) done_in = 1'b1;
            if (inj == 2 && k == 7) begin
                rst = 1'b0;
                #1;
                chk("t5_valid_in_reset", sif.valid, 0);
                chk("t5_busy_in_reset", busy, 0);
                repeat (2) @(posedge clk);
                #2 rst = 1'b1;
                return;
            end
            @(posedge clk); #1;
            start = 1'b0;
            done_in = 1'b0;
        end
        sif.ready = 1'b1;
        t = 0;
        while (busy && t < 200) begin
            @(negedge clk);
            t++;
        end
        chk("idle_timeout", 32'(t < 200), 1);
        @(negedge clk);
    endtask

    logic [15:0] eol_mask = 16'h8888;
    logic [15:0] eof_mask = 16'h8000;

    task automatic check_beats(input string tag, input int cnt, input logic [23:0] base);
        chk({tag, "_beats"}, log_n - lb, cnt);
        for (int i = 0; i < cnt && lb + i < log_n; i++) begin
            chk({tag, "_data"}, log_d[lb+i], base + 24'(i));
            chk({tag, "_eol"}, log_l[lb+i], eol_mask[i]);
            chk({tag, "_eof"}, log_f[lb+i], eof_mask[i]);
        end
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

    initial begin : stim
        sif.ready = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_valid", sif.valid, 0);
        chk("rst_data", sif.data, 0);
        chk("rst_eol_eof", {sif.eol, sif.eof}, 0);
        chk("rst_busy", busy, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_frame_done", frame_done, 0);
        @(posedge clk); #1 rst = 1'b1;

        // Test 1: basic frame
        for (int k = 0; k < N; k++) pix_tab[k] = 24'(k);
        run_frame(0, 0);
        check_beats("t1", 16, 24'h000000);
        chk("t1_overflow", overflow, 0);
        chk("t1_frame_done_pulses", fd_cnt - fb, 1);

        // Test 2: no ready during capture, only the first 4 survive
        run_frame(99, 0);
        check_beats("t2", 4, 24'h000000);
        chk("t2_overflow", overflow, 1);
        chk("t2_busy", busy, 0);

        // Test 3: full FIFO with simultaneous pop keeps every pixel
        for (int k = 0; k < N; k++) pix_tab[k] = 24'h0A0000 + 24'(k);
        run_frame(4, 0);
        check_beats("t3", 16, 24'h0A0000);
        chk("t3_overflow", overflow, 0);

        // Test 4: start and done_in during capture are ignored
        for (int k = 0; k < N; k++) pix_tab[k] = 24'h300000 + 24'(k);
        run_frame(0, 1);
        check_beats("t4", 16, 24'h300000);
        chk("t4_frame_done_pulses", fd_cnt - fb, 1);

        // Test 5: reset mid-frame, then a clean frame
        run_frame(0, 2);
        for (int k = 0; k < N; k++) pix_tab[k] = 24'h123400 + 24'(k);
        run_frame(0, 0);
        check_beats("t5", 16, 24'h123400);
        chk("t5_overflow", overflow, 0);

        // Test 6: colour conversion path
        for (int k = 0; k < N; k++) pix_tab[k] = 24'(k);
        pix_tab[0] = 24'hFF0000;
        pix_tab[1] = 24'hFFFFFF;
        pix_tab[2] = 24'h00FF00;
        run_frame(0, 0);
        chk("t6_beats", log_n - lb, 16);
`ifdef STREAM_GRAY_EN
        chk("t6_red", log_d[lb], 24'h4C4C4C);
        chk("t6_white", log_d[lb+1], 24'hFFFFFF);
        chk("t6_green", log_d[lb+2], 24'h959595);
`else
        chk("t6_red", log_d[lb], 24'hFF0000);
        chk("t6_white", log_d[lb+1], 24'hFFFFFF);
        chk("t6_green", log_d[lb+2], 24'h00FF00);
`endif

        repeat (2) @(negedge clk);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

`default_nettype wire
